mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arb_starve_cnt.sv | 38 +++
 rtl/mem_arbiter.sv | 89 ++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } owner_state_t;

    localparam logic [2:0] FUNCT3_WORD        = 3'b010;
    localparam int         STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of data grants taken while fetch waits; raises override at the limit.
module mem_arb_starve_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic override_o
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign override_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous memory between fetch and data requesters.
// Define MEM_ARBITER_FAIR_EN to add the fetch-starvation override; otherwise data has strict priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_funct3,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
        $error("mem_arbiter: STARVE_MAX must be in 1..15");
    end

    owner_state_t state_q;
    logic         fetch_grant;
    logic         data_grant;
    logic         starve_override;

`ifdef MEM_ARBITER_FAIR_EN
    mem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (data_grant & if_req),
        .clr_i      (fetch_grant | ~if_req),
        .override_o (starve_override)
    );
`else
    assign starve_override = 1'b0;
`endif

    // Reset gates both grants so the memory port is quiet while rst is low.
    assign data_grant  = rst & d_req & ~(if_req & starve_override);
    assign fetch_grant = rst & if_req & ~data_grant;

    assign if_stall = if_req & ~fetch_grant;
    assign d_stall  = d_req & ~data_grant;

    assign mem_en     = fetch_grant | data_grant;
    assign mem_we     = data_grant & d_we;
    assign mem_addr   = data_grant ? d_addr : if_addr;
    assign mem_wdata  = data_grant ? d_wdata : '0;
    assign mem_funct3 = data_grant ? d_funct3 : FUNCT3_WORD;

    // Owner of the read data returning on the next cycle; a new grant always overrides.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else if (fetch_grant) begin
            state_q <= RESP_IF;
        end else if (data_grant) begin
            state_q <= RESP_D;
        end else begin
            state_q <= IDLE;
        end
    end

    assign if_valid = (state_q == RESP_IF);
    assign d_valid  = (state_q == RESP_D);
    assign busy     = (state_q != IDLE);
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign d_rdata  = d_valid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, starvation/reset sequences, random vs model.
module tb_mem_arbiter;

    localparam int SMAX = 4;
`ifdef MEM_ARBITER_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .if_stall   (if_stall),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_funct3   (d_funct3),
        .d_rdata    (d_rdata),
        .d_valid    (d_valid),
        .d_stall    (d_stall),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_funct3 (mem_funct3),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        dReq;
        logic        dWe;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic [2:0]  dFunct3;
        logic [31:0] memRdata;
        logic        expIfStall;
        logic        expDStall;
        logic        expMemEn;
        logic        expMemWe;
        logic [31:0] expMemAddr;
        logic [2:0]  expMemFunct3;
        logic        expIfValid;
        logic        expDValid;
        logic [31:0] expRdata;
        logic        chkRdata;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] ir, input logic [31:0] ia, input logic [31:0] dr,
        input logic [31:0] dw, input logic [31:0] da, input logic [31:0] dd,
        input logic [31:0] df, input logic [31:0] mr,
        input logic [31:0] eis, input logic [31:0] eds, input logic [31:0] een,
        input logic [31:0] ewe, input logic [31:0] ead, input logic [31:0] ef3,
        input logic [31:0] eiv, input logic [31:0] edv, input logic [31:0] erd,
        input logic [31:0] ck);
        vec_t v;
        v.ifReq = ir[0]; v.ifAddr = ia; v.dReq = dr[0]; v.dWe = dw[0];
        v.dAddr = da; v.dWdata = dd; v.dFunct3 = df[2:0]; v.memRdata = mr;
        v.expIfStall = eis[0]; v.expDStall = eds[0]; v.expMemEn = een[0];
        v.expMemWe = ewe[0]; v.expMemAddr = ead; v.expMemFunct3 = ef3[2:0];
        v.expIfValid = eiv[0]; v.expDValid = edv[0]; v.expRdata = erd;
        v.chkRdata = ck[0];
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        if_req    = v.ifReq;
        if_addr   = v.ifAddr;
        d_req     = v.dReq;
        d_we      = v.dWe;
        d_addr    = v.dAddr;
        d_wdata   = v.dWdata;
        d_funct3  = v.dFunct3;
        mem_rdata = v.memRdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t idleVec(input logic [31:0] mr);
        return mk(0, 0, 0, 0, 0, 0, 0, mr, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    vec_t vecs[9];

    // Reference model state: who owns next cycle's read data, and how many data grants fetch has watched.
    int respOwner;
    bit respWrite;
    int starve;

    initial begin
        vec_t v;
        int   ifPulses;
        bit   expStall, expIv, expDv;

        vecs[0] = mk(1, 32'h10, 0, 0, 0, 0, 0, 0,            0, 0, 1, 0, 32'h10, 2, 0, 0, 0, 0);
        vecs[1] = mk(0, 0, 0, 0, 0, 0, 0, 32'h00500093,      0, 0, 0, 0, 0, 0, 1, 0, 32'h00500093, 1);
        vecs[2] = mk(1, 32'h14, 1, 0, 32'h40, 0, 2, 0,       1, 0, 1, 0, 32'h40, 2, 0, 0, 0, 0);
        vecs[3] = mk(1, 32'h14, 0, 0, 0, 0, 0, 32'h11111111, 0, 0, 1, 0, 32'h14, 2, 0, 1, 32'h11111111, 1);
        vecs[4] = mk(0, 0, 1, 1, 32'h20, 32'hDEADBEEF, 0, 32'h22222222,
                                                             0, 0, 1, 1, 32'h20, 0, 1, 0, 32'h22222222, 1);
        vecs[5] = mk(0, 0, 0, 0, 0, 0, 0, 32'h33333333,      0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[6] = mk(1, 32'h18, 1, 0, 32'h44, 0, 4, 32'h44444444,
                                                             1, 0, 1, 0, 32'h44, 4, 0, 0, 0, 0);
        vecs[7] = mk(0, 0, 0, 0, 0, 0, 0, 32'h55555555,      0, 0, 0, 0, 0, 0, 0, 1, 32'h55555555, 1);
        vecs[8] = mk(0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with both requests present: no grants, stalls mirror requests.
        rst = 1'b0;
        v = mk(1, 32'h10, 1, 0, 32'h40, 0, 2, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(v);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_mem_en", 32'(mem_en), 0);
        checkOutput("rst_if_stall", 32'(if_stall), 1);
        checkOutput("rst_d_stall", 32'(d_stall), 1);
        checkOutput("rst_if_valid", 32'(if_valid), 0);
        checkOutput("rst_d_valid", 32'(d_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_if_rdata", if_rdata, 0);
        checkOutput("rst_d_rdata", d_rdata, 0);
        applyStimulus(idleVec(0));
        rst = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("tbl%0d_if_stall", i), 32'(if_stall), 32'(vecs[i].expIfStall));
            checkOutput($sformatf("tbl%0d_d_stall", i), 32'(d_stall), 32'(vecs[i].expDStall));
            checkOutput($sformatf("tbl%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].expMemEn));
            checkOutput($sformatf("tbl%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].expIfValid));
            checkOutput($sformatf("tbl%0d_d_valid", i), 32'(d_valid), 32'(vecs[i].expDValid));
            if (vecs[i].expMemEn) begin
                checkOutput($sformatf("tbl%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].expMemWe));
                checkOutput($sformatf("tbl%0d_mem_addr", i), mem_addr, vecs[i].expMemAddr);
                checkOutput($sformatf("tbl%0d_mem_funct3", i), 32'(mem_funct3), 32'(vecs[i].expMemFunct3));
                if (vecs[i].expMemWe)
                    checkOutput($sformatf("tbl%0d_mem_wdata", i), mem_wdata, vecs[i].dWdata);
            end
            if (vecs[i].chkRdata && vecs[i].expIfValid)
                checkOutput($sformatf("tbl%0d_if_rdata", i), if_rdata, vecs[i].expRdata);
            if (vecs[i].chkRdata && vecs[i].expDValid)
                checkOutput($sformatf("tbl%0d_d_rdata", i), d_rdata, vecs[i].expRdata);
            @(posedge clk);
        end

        // Both requesters held for 10 cycles, then released for one observation cycle.
        ifPulses = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c <= 10)
                applyStimulus(mk(1, 32'h100 + 32'(c), 1, 0, 32'h200 + 32'(c), 0, 2, 32'(c),
                                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            else
                applyStimulus(idleVec(32'(c)));
            #1;
            if (FAIR) begin
                expStall = (c <= 10) && !(c == 5 || c == 10);
                expIv    = (c == 6 || c == 11);
                expDv    = (c >= 2) && !expIv;
            end else begin
                expStall = (c <= 10);
                expIv    = 1'b0;
                expDv    = (c >= 2);
            end
            checkOutput($sformatf("starve_c%0d_if_stall", c), 32'(if_stall), 32'(expStall));
            checkOutput($sformatf("starve_c%0d_if_valid", c), 32'(if_valid), 32'(expIv));
            checkOutput($sformatf("starve_c%0d_d_valid", c), 32'(d_valid), 32'(expDv));
            if (if_valid) ifPulses++;
            @(posedge clk);
        end
        checkOutput("starve_if_pulses", 32'(ifPulses), FAIR ? 32'd2 : 32'd0);

        // Fetch granted, then reset lands mid-cycle before its response edge.
        @(negedge clk);
        applyStimulus(mk(1, 32'h30, 0, 0, 0, 0, 0, 32'h77777777, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checkOutput("rstmid_if_stall", 32'(if_stall), 0);
        @(posedge clk);
        #2;
        checkOutput("rstmid_busy_before", 32'(busy), 1);
        rst = 1'b0;
        #1;
        checkOutput("rstmid_if_valid", 32'(if_valid), 0);
        checkOutput("rstmid_busy", 32'(busy), 0);
        checkOutput("rstmid_if_rdata", if_rdata, 0);
        checkOutput("rstmid_mem_en", 32'(mem_en), 0);
        @(negedge clk);
        applyStimulus(idleVec(32'h77777777));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rstmid_after_if_valid", 32'(if_valid), 0);
        checkOutput("rstmid_after_busy", 32'(busy), 0);

        // Randomized traffic against the reference model, with occasional reset pulses.
        respOwner = 0;
        respWrite = 1'b0;
        starve    = 0;
        for (int n = 0; n < 600; n++) begin
            bit ovr, gD, gF;
            @(negedge clk);
            v = mk(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) != 0),
                   32'($urandom_range(0, 1)), $urandom, $urandom, 32'($urandom_range(0, 7)), $urandom,
                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            applyStimulus(v);
            rst = ($urandom_range(0, 49) != 0);
            #1;
            if (!rst) begin
                respOwner = 0;
                starve    = 0;
            end
            ovr = FAIR && (starve >= SMAX);
            gD  = rst && v.dReq && !(v.ifReq && ovr);
            gF  = rst && v.ifReq && !gD;
            checkOutput("rnd_if_stall", 32'(if_stall), 32'(v.ifReq && !gF));
            checkOutput("rnd_d_stall", 32'(d_stall), 32'(v.dReq && !gD));
            checkOutput("rnd_mem_en", 32'(mem_en), 32'(gD || gF));
            checkOutput("rnd_if_valid", 32'(if_valid), 32'(respOwner == 1));
            checkOutput("rnd_d_valid", 32'(d_valid), 32'(respOwner == 2));
            checkOutput("rnd_busy", 32'(busy), 32'(respOwner != 0));
            if (gD || gF) begin
                checkOutput("rnd_mem_we", 32'(mem_we), 32'(gD && v.dWe));
                checkOutput("rnd_mem_addr", mem_addr, gD ? v.dAddr : v.ifAddr);
                checkOutput("rnd_mem_funct3", 32'(mem_funct3), gD ? 32'(v.dFunct3) : 32'd2);
                if (gD && v.dWe)
                    checkOutput("rnd_mem_wdata", mem_wdata, v.dWdata);
            end
            if (respOwner == 1)
                checkOutput("rnd_if_rdata", if_rdata, v.memRdata);
            if (respOwner == 2 && !respWrite)
                checkOutput("rnd_d_rdata", d_rdata, v.memRdata);
            @(posedge clk);
            if (rst) begin
                respOwner = gF ? 1 : (gD ? 2 : 0);
                respWrite = gD && v.dWe;
                if (gF || !v.ifReq)
                    starve = 0;
                else if (gD && starve < SMAX)
                    starve = starve + 1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
